// File: rtl/eng_arbiter.sv
// Round-robin arbiter that shares one start/done compute engine between two
// requesters, with a bounded wait and an error-flagged response on timeout.
module eng_arbiter #(
  parameter int DW      = 16,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [RW-1:0] dout,
  output logic          grant_id,
  output logic          busy,
  output logic          eng_start,
  output logic [DW-1:0] eng_din,
  input  logic          eng_done,
  input  logic [RW-1:0] eng_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_r;
  state_t        next_state_s;
  logic          grant_s;
  logic          win_s;
  logic          timeout_s;
  logic          ptr_r;
  logic [7:0]    wcnt_r;
  logic          grant_id_r;
  logic [DW-1:0] eng_din_r;
  logic [RW-1:0] dout_r;
  logic          err_r;

  assign timeout_s = (wcnt_r == WCNT_LAST);

  // Next-state and grant selection; done is checked before timeout so it wins a tie.
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    win_s        = grant_id_r;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          grant_s      = 1'b1;
          win_s        = ptr_r;
          next_state_s = START;
        end else if (req0) begin
          grant_s      = 1'b1;
          win_s        = 1'b0;
          next_state_s = START;
        end else if (req1) begin
          grant_s      = 1'b1;
          win_s        = 1'b1;
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: next_state_s = WAIT;
      WAIT: begin
        if (eng_done) begin
          next_state_s = RESP;
        end else if (timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, grant, operand, wait counter, result and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      ptr_r      <= 1'b0;
      wcnt_r     <= 8'd0;
      grant_id_r <= 1'b0;
      eng_din_r  <= {DW{1'b0}};
      dout_r     <= {RW{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (grant_s) begin
        grant_id_r <= win_s;
        eng_din_r  <= win_s ? din1 : din0;
      end
      case (state_r)
        START: wcnt_r <= 8'd0;
        WAIT: begin
          if (eng_done) begin
            dout_r <= eng_dout;
            err_r  <= 1'b0;
          end else if (timeout_s) begin
            err_r <= 1'b1;
          end else begin
            wcnt_r <= wcnt_r + 8'd1;
          end
        end
        RESP:    ptr_r <= ~grant_id_r;
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers so no input reaches an output combinationally.
  assign busy      = (state_r != IDLE);
  assign eng_start = (state_r == START);
  assign ack0      = (state_r == RESP) && !grant_id_r;
  assign ack1      = (state_r == RESP) && grant_id_r;
  assign err       = (state_r == RESP) && err_r;
  assign dout      = dout_r;
  assign grant_id  = grant_id_r;
  assign eng_din   = eng_din_r;

endmodule
